// File: rtl/inv_round_pipe.sv
// inv_round_pipe: one AES inverse-cipher round, 3-stage valid/ready pipe.
// Optional macro DLU_LAST_ROUND_EN adds last_in to skip InvMixColumns.
module inv_round_pipe #(
  parameter int W_DATA = 128,
  parameter int W_KEY  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_DATA-1:0] data_in,
  input  logic [W_KEY-1:0]  roundkey,
`ifdef DLU_LAST_ROUND_EN
  input  logic              last_in,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_DATA-1:0] data_out
);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Inverse affine, then a^254 == a^-1 (0 maps to 0)
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] a;
    logic [7:0] r;
    logic [7:0] s;
    a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]}
      ^ {b[1:0], b[7:2]} ^ 8'h05;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic [127:0] isr_isb(
    input logic [127:0] d
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] =
          inv_sbox(d[127-8*(4*((c+4-r)&3)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] mulk(
    input logic [7:0] a,
    input logic [3:0] k
  );
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00)
         ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? a : 8'h00);
  endfunction

  function automatic logic [31:0] imc_col(input logic [31:0] w);
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    logic [31:0] o;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    o[31:24] = mulk(a0, 4'he) ^ mulk(a1, 4'hb)
             ^ mulk(a2, 4'hd) ^ mulk(a3, 4'h9);
    o[23:16] = mulk(a0, 4'h9) ^ mulk(a1, 4'he)
             ^ mulk(a2, 4'hb) ^ mulk(a3, 4'hd);
    o[15:8]  = mulk(a0, 4'hd) ^ mulk(a1, 4'h9)
             ^ mulk(a2, 4'he) ^ mulk(a3, 4'hb);
    o[7:0]   = mulk(a0, 4'hb) ^ mulk(a1, 4'hd)
             ^ mulk(a2, 4'h9) ^ mulk(a3, 4'he);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] d);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = imc_col(d[127-32*c -: 32]);
    end
    return o;
  endfunction

  logic              v1;
  logic              v2;
  logic              v3;
  logic              stall;
  logic [W_DATA-1:0] s1_d;
  logic [W_KEY-1:0]  s1_k;
  logic [W_DATA-1:0] s2_d;
  logic [W_DATA-1:0] s3_d;

  // Whole-pipe stall: any held output freezes every stage
  assign stall     = v3 && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = v3;

`ifdef DLU_LAST_ROUND_EN
  logic l1;
  logic l2;

  assign s3_d = l2 ? s2_d : inv_mix(s2_d);

  always_ff @(posedge clk) begin
    if (!rst) begin
      l1 <= 1'b0;
      l2 <= 1'b0;
    end else if (!stall) begin
      if (in_valid) l1 <= last_in;
      if (v1)       l2 <= l1;
    end
  end
`else
  assign s3_d = inv_mix(s2_d);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      s1_d     <= '0;
      s1_k     <= '0;
      s2_d     <= '0;
      data_out <= '0;
    end else if (!stall) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      if (in_valid) begin
        s1_d <= isr_isb(data_in);
        s1_k <= roundkey;
      end
      if (v1) s2_d     <= s1_d ^ s1_k;
      if (v2) data_out <= s3_d;
    end
  end

endmodule
